// File: rtl/demux_1_8_reg_v.sv
// Registered 1:8 demultiplexer / scan deserializer: addressed slot writes or sequential scan with frame strobe.
// Optional even parity of the published frame is enabled with the DEMUX_PARITY_EN macro.
module demux_1_8_reg_v #(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_d,
    input  logic [2:0] i_sel_code,
    input  logic       i_auto,
    input  logic       i_clr,
    output logic [7:0] o_code,
    output logic [2:0] o_idx,
    output logic       o_busy,
    output logic [7:0] o_frame,
    output logic       o_frame_vld,
    output logic       o_parity
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] code_q,  code_d;
    logic [7:0] frame_q, frame_d;
    logic [2:0] idx_q,   idx_d;
    logic       vld_q,   vld_d;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        vld_d   = 1'b0;
        if (i_clr) begin
            code_d  = RST_VAL;
            idx_d   = '0;
            state_d = IDLE;
        end else if (!i_auto) begin
            // Leaving scan mode abandons any partial frame; written bits stay in code.
            idx_d   = '0;
            state_d = IDLE;
            if (i_en) begin
                code_d[i_sel_code] = i_d;
            end
        end else if (i_en) begin
            code_d[idx_q] = i_d;
            idx_d         = idx_q + 3'd1;
            state_d       = FILL;
            if (idx_q == 3'd7) begin
                frame_d = {i_d, code_q[6:0]};
                vld_d   = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            code_q  <= RST_VAL;
            frame_q <= RST_VAL;
            idx_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
        end
    end

`ifdef DEMUX_PARITY_EN
    logic par_q;

    // Parity follows frame updates only, so i_clr leaves it untouched.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            par_q <= 1'b0;
        end else if (vld_d) begin
            par_q <= ^frame_d;
        end
    end

    assign o_parity = par_q;
`else
    assign o_parity = 1'b0;
`endif

    assign o_code      = code_q;
    assign o_idx       = idx_q;
    assign o_busy      = (state_q == FILL);
    assign o_frame     = frame_q;
    assign o_frame_vld = vld_q;

endmodule

// File: tb/tb_demux_1_8_reg_v.sv
// Directed self-checking bench for demux_1_8_reg_v: table of single-cycle vectors plus multi-cycle sequences.
module tb_demux_1_8_reg_v;

    logic       clk, rst, en, d, am, clr;
    logic [2:0] sel;
    logic [7:0] code, frame;
    logic [2:0] idx;
    logic       busy, vld, par;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned pulses;

    typedef struct {
        logic       en;
        logic       d;
        logic [2:0] sel;
        logic       am;
        logic       clr;
        logic [7:0] code;
        logic [2:0] idx;
        logic       busy;
        logic [7:0] frame;
        logic       vld;
    } vec_t;

    vec_t vecs[13];

    demux_1_8_reg_v #(.RST_VAL(8'h00)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_d(d), .i_sel_code(sel),
        .i_auto(am), .i_clr(clr), .o_code(code), .o_idx(idx), .o_busy(busy),
        .o_frame(frame), .o_frame_vld(vld), .o_parity(par)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic step(input logic e, input logic dd, input logic [2:0] s,
                        input logic a, input logic c);
        en = e; d = dd; sel = s; am = a; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] ec, input logic [2:0] ei,
                           input logic eb, input logic [7:0] ef, input logic ev);
        chk({tag, ".code"},  32'(code),  32'(ec));
        chk({tag, ".idx"},   32'(idx),   32'(ei));
        chk({tag, ".busy"},  32'(busy),  32'(eb));
        chk({tag, ".frame"}, 32'(frame), 32'(ef));
        chk({tag, ".vld"},   32'(vld),   32'(ev));
    endtask

    initial begin
        //            en    d     sel   am    clr   code   idx   busy  frame  vld
        vecs[0]  = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 8'h08, 3'd0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 8'h88, 3'd0, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 8'h80, 3'd0, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 3'd6, 1'b1, 1'b0, 8'h01, 3'd1, 1'b1, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'd6, 1'b1, 1'b0, 8'h01, 3'd2, 1'b1, 8'h00, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 3'd6, 1'b1, 1'b0, 8'h05, 3'd3, 1'b1, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'd6, 1'b1, 1'b0, 8'h05, 3'd4, 1'b1, 8'h00, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'd6, 1'b1, 1'b0, 8'h05, 3'd5, 1'b1, 8'h00, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 3'd6, 1'b1, 1'b0, 8'h25, 3'd6, 1'b1, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'd6, 1'b1, 1'b0, 8'h25, 3'd7, 1'b1, 8'h00, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 3'd6, 1'b1, 1'b0, 8'hA5, 3'd0, 1'b0, 8'hA5, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'hA5, 3'd0, 1'b0, 8'hA5, 1'b0};

        rst = 1'b1; en = 1'b0; d = 1'b0; sel = '0; am = 1'b0; clr = 1'b0;
        #12;
        chk_all("reset", 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
        chk("reset.parity", 32'(par), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int unsigned i = 0; i < 13; i++) begin
            step(vecs[i].en, vecs[i].d, vecs[i].sel, vecs[i].am, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].code, vecs[i].idx, vecs[i].busy,
                    vecs[i].frame, vecs[i].vld);
        end
        chk("a5.parity", 32'(par), 32'd0);

        // Gap mid-frame: 3 writes, 5 idle cycles, 5 writes -> one pulse, frame 07.
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        for (int unsigned i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        chk("gap.code", 32'(code), 32'h07);
        pulses = 0;
        for (int unsigned i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
            chk($sformatf("gap.idx%0d", i), 32'(idx), 32'd3);
            if (vld) pulses++;
        end
        for (int unsigned i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
            if (vld) pulses++;
        end
        chk("gap.frame", 32'(frame), 32'h07);
        chk("gap.vld_last", 32'(vld), 32'd1);
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        if (vld) pulses++;
        chk("gap.pulses", 32'(pulses), 32'd1);
`ifdef DEMUX_PARITY_EN
        chk("gap.parity", 32'(par), 32'd1);
`else
        chk("gap.parity", 32'(par), 32'd0);
`endif

        // Clear at idx 5 together with a write: write lost, frame held.
        for (int unsigned i = 0; i < 5; i++) step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        chk("clr.pre_code", 32'(code), 32'h1F);
        chk("clr.pre_idx", 32'(idx), 32'd5);
        step(1'b1, 1'b1, 3'd0, 1'b1, 1'b1);
        chk_all("clr", 8'h00, 3'd0, 1'b0, 8'h07, 1'b0);
`ifdef DEMUX_PARITY_EN
        chk("clr.parity", 32'(par), 32'd1);
`endif
        step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        chk("clr.next_code", 32'(code), 32'h01);
        chk("clr.next_idx", 32'(idx), 32'd1);

        // Drop i_auto at idx 4: index resets, code kept, next write in slot 0.
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        for (int unsigned i = 0; i < 4; i++) step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        chk("mode.pre_idx", 32'(idx), 32'd4);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk_all("mode", 8'h0F, 3'd0, 1'b0, 8'h07, 1'b0);
        step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
        chk("mode.next_code", 32'(code), 32'h0E);
        chk("mode.next_idx", 32'(idx), 32'd1);

        // Asynchronous reset between edges at idx 6.
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        for (int unsigned i = 0; i < 6; i++) step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        chk("arst.pre_idx", 32'(idx), 32'd6);
        #2;
        rst = 1'b1;
        #1;
        chk_all("arst", 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
        chk("arst.parity", 32'(par), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        chk("arst.first_code", 32'(code), 32'h01);
        chk("arst.first_idx", 32'(idx), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
